homography_fetch_responder: RTL and testbench

- Homography-side responder to the sync controller's query/start interface.
- Accepts one pixel query per cycle while start=1 and queues it in order.
- Fetches RGB565 from the frame memory through a req/ack port.
- Returns return_x/return_y plus r/g/b with a one-cycle ready pulse per query, strictly in query order.

---
 rtl/homography_fetch_responder.sv | 249 ++++++++++++++++++++++++
 tb/tb_homography_fetch_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/homography_fetch_responder.sv
// -----------------------------------------------------------------------------
// homography_fetch_responder
//
// Homography-side responder for the sync controller's query/start interface.
// Each cycle with start=1 carries one pixel query {query_x, query_y}. Queries
// are queued in order, fetched as RGB565 words from frame memory over a
// req/ack port, and returned one per ready pulse, strictly in query order.
//
// Ports:
//   clk_25     in   pixel clock
//   rst_n      in   asynchronous active-low reset
//   start      in   query strobe, query_x/query_y valid while high
//   query_x    in   [9:0]  query column
//   query_y    in   [9:0]  query row
//   return_x   out  [9:0]  echoed column of the current result
//   return_y   out  [9:0]  echoed row of the current result
//   r, g, b    out  [4:0]/[5:0]/[4:0] colour of the current result
//   ready      out  one-cycle result strobe
//   mem_req    out  frame memory read request
//   mem_addr   out  [ADDR_W-1:0] read word address (y*H_ACTIVE + x)
//   mem_rdata  in   [15:0] RGB565 read data, valid with mem_ack
//   mem_ack    in   read complete (may arrive in the first mem_req cycle)
//   overflow   out  sticky flag: a query was dropped because the queue was full
//   pending    out  [DEPTH_LOG2:0] queries accepted but not yet returned
//
// Build option:
//   COORD_CLAMP_EN  when defined, out-of-range coordinates are clamped to the
//                   frame edge and fetched; otherwise they return black without
//                   a memory access. return_x/y always echo the raw query.
// -----------------------------------------------------------------------------
module homography_fetch_responder #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 19,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk_25,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [9:0]            query_x,
  input  logic [9:0]            query_y,
  output logic [9:0]            return_x,
  output logic [9:0]            return_y,
  output logic [4:0]            r,
  output logic [5:0]            g,
  output logic [4:0]            b,
  output logic                  ready,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   pending
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [31:0] H_U = 32'(H_ACTIVE);
  localparam logic [31:0] V_U = 32'(V_ACTIVE);
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [9:0]            cur_x_q, cur_x_d;
  logic [9:0]            cur_y_q, cur_y_d;
  logic [9:0]            ret_x_q, ret_x_d;
  logic [9:0]            ret_y_q, ret_y_d;
  logic [4:0]            r_q, r_d;
  logic [5:0]            g_q, g_d;
  logic [4:0]            b_q, b_d;
  logic                  ready_q, ready_d;
  logic                  overflow_q, overflow_d;
  logic [DEPTH_LOG2:0]   pending_q, pending_d;
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [19:0]           fifo_q [DEPTH];

  logic                  fifo_empty;
  logic [19:0]           head;
  logic [9:0]            head_x, head_y;
  logic [9:0]            eff_x, eff_y;
  logic                  fetch_ok;
  logic [ADDR_W-1:0]     head_addr;
  logic                  pop;
  logic                  accept;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head       = fifo_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign head_x     = head[19:10];
  assign head_y     = head[9:0];

  // Decide whether the queue head needs a memory fetch and which coordinates address it.
  always_comb begin
`ifdef COORD_CLAMP_EN
    fetch_ok = 1'b1;
    eff_x    = (32'(head_x) >= H_U) ? 10'(H_ACTIVE - 1) : head_x;
    eff_y    = (32'(head_y) >= V_U) ? 10'(V_ACTIVE - 1) : head_y;
`else
    fetch_ok = (32'(head_x) < H_U) && (32'(head_y) < V_U);
    eff_x    = head_x;
    eff_y    = head_y;
`endif
    // Product formed at ADDR_W width, i.e. the exact address truncated to the port.
    head_addr = ADDR_W'(eff_y) * ADDR_W'(H_ACTIVE) + ADDR_W'(eff_x);
  end

  // Fetch FSM: pops the queue, drives the memory port and builds each result.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    ret_x_d    = ret_x_q;
    ret_y_d    = ret_y_q;
    r_d        = r_q;
    g_d        = g_q;
    b_d        = b_q;
    ready_d    = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_x_d = head_x;
          cur_y_d = head_y;
          if (fetch_ok) begin
            mem_req_d  = 1'b1;
            mem_addr_d = head_addr;
            state_d    = S_REQ;
          end else begin
            // Out-of-frame query: answer black immediately, no memory access.
            ready_d = 1'b1;
            ret_x_d = head_x;
            ret_y_d = head_y;
            r_d     = 5'd0;
            g_d     = 6'd0;
            b_d     = 5'd0;
          end
        end else begin
          mem_req_d = 1'b0;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          ready_d = 1'b1;
          ret_x_d = cur_x_q;
          ret_y_d = cur_y_q;
          r_d     = mem_rdata[15:11];
          g_d     = mem_rdata[10:5];
          b_d     = mem_rdata[4:0];
          // Chain straight into the next fetch. An out-of-frame head is left
          // for S_IDLE so that it gets its own ready pulse next cycle.
          if (!fifo_empty && fetch_ok) begin
            pop        = 1'b1;
            cur_x_d    = head_x;
            cur_y_d    = head_y;
            mem_addr_d = head_addr;
            mem_req_d  = 1'b1;
          end else begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Queue bookkeeping. Capacity counts the in-flight query too, so a retiring
  // result on the same edge frees a slot for the incoming query.
  always_comb begin
    accept     = start && ((pending_q < DEPTH_C) || ready_d);
    overflow_d = overflow_q | (start & ~accept);
    wr_ptr_d   = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, accept};
    rd_ptr_d   = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop};
    pending_d  = pending_q + {{DEPTH_LOG2{1'b0}}, accept} - {{DEPTH_LOG2{1'b0}}, ready_d};
  end

  // Control and output registers.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      cur_x_q    <= 10'd0;
      cur_y_q    <= 10'd0;
      ret_x_q    <= 10'd0;
      ret_y_q    <= 10'd0;
      r_q        <= 5'd0;
      g_q        <= 6'd0;
      b_q        <= 5'd0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      ret_x_q    <= ret_x_d;
      ret_y_q    <= ret_y_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Query storage, written at the tail on each accepted query.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= 20'd0;
      end
    end else if (accept) begin
      fifo_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {query_x, query_y};
    end
  end

  assign return_x = ret_x_q;
  assign return_y = ret_y_q;
  assign r        = r_q;
  assign g        = g_q;
  assign b        = b_q;
  assign ready    = ready_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign overflow = overflow_q;
  assign pending  = pending_q;

endmodule

// File: tb/tb_homography_fetch_responder.sv
module tb_homography_fetch_responder;

  typedef logic [35:0] res_t;

  logic        clk_25 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic [9:0]  query_x = 10'd0;
  logic [9:0]  query_y = 10'd0;
  logic [9:0]  return_x, return_y;
  logic [4:0]  r, b;
  logic [5:0]  g;
  logic        ready, mem_req, mem_ack, overflow;
  logic [18:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [3:0]  pending;

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          wait_cnt = 0;
  logic [1:0]  ack_mode = 2'd0;   // 0 ack at once, 1 ack low, 2 two-cycle wait, 3 forced high
  logic        fixed_en = 1'b0;
  logic [15:0] fixed_val = 16'h0000;
  logic        prev_hold = 1'b0;
  logic [18:0] prev_addr = 19'd0;
  res_t        got[$];
  int          got_cyc[$];
  res_t        exp_q[$];

  homography_fetch_responder dut (
    .clk_25(clk_25), .rst_n(rst_n), .start(start),
    .query_x(query_x), .query_y(query_y),
    .return_x(return_x), .return_y(return_y),
    .r(r), .g(g), .b(b), .ready(ready),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .overflow(overflow), .pending(pending)
  );

  always #20 clk_25 = ~clk_25;

  // Frame memory model: pixel word is a fixed scramble of its address.
  assign mem_rdata = fixed_en ? fixed_val : (mem_addr[15:0] ^ 16'h5A5A);
  assign mem_ack   = (ack_mode == 2'd3) ||
                     (mem_req && ((ack_mode == 2'd0) || (ack_mode == 2'd2 && wait_cnt == 2)));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t pix(input logic [9:0] x, input logic [9:0] y,
                               input logic [9:0] ax, input logic [9:0] ay, input bit fetched);
    logic [31:0] a;
    logic [15:0] d;
    a = 32'(ay) * 32'd640 + 32'(ax);
    d = a[15:0] ^ 16'h5A5A;
    if (fetched) return {x, y, d[15:11], d[10:5], d[4:0]};
    else         return {x, y, 16'h0000};
  endfunction

  // Cycle counter and wait-state counter for the memory model.
  always @(posedge clk_25) begin
    cyc <= cyc + 1;
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // Result collector and address-hold monitor, sampled mid-cycle.
  always @(negedge clk_25) begin
    if (ready) begin
      got.push_back({return_x, return_y, r, g, b});
      got_cyc.push_back(cyc);
    end
    if (prev_hold && rst_n) begin
      check_eq("addr_hold", {45'd0, mem_addr}, {45'd0, prev_addr});
      check_eq("req_hold", {63'd0, mem_req}, 64'd1);
    end
    prev_hold <= mem_req && !mem_ack && rst_n;
    prev_addr <= mem_addr;
  end

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic clear_results();
    got.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic wait_results(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) tick();
    check_eq("result_count", 64'(got.size()), 64'(n));
  endtask

  task automatic compare_results(input string tag);
    res_t v;
    for (int i = 0; i < exp_q.size(); i++) begin
      v = (i < got.size()) ? got[i] : '1;
      check_eq(tag, {28'd0, v}, {28'd0, exp_q[i]});
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    #5 rst_n = 1'b1;
    tick();
    check_eq("rst_ready", 64'(ready), 64'd0);
    check_eq("rst_req", 64'(mem_req), 64'd0);
    check_eq("rst_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_pending", 64'(pending), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_ret", {28'd0, return_x, return_y, r, g, b}, 64'd0);

    // Single in-range query with immediate ack
    clear_results();
    fixed_en = 1'b1; fixed_val = 16'hF81F; ack_mode = 2'd0;
    start = 1'b1; query_x = 10'd3; query_y = 10'd2;
    tick();
    start = 1'b0;
    check_eq("t1_pending_acc", 64'(pending), 64'd1);
    check_eq("t1_req_e", 64'(mem_req), 64'd0);
    tick();
    check_eq("t1_req", 64'(mem_req), 64'd1);
    check_eq("t1_addr", 64'(mem_addr), 64'd1283);
    check_eq("t1_ready_early", 64'(ready), 64'd0);
    tick();
    check_eq("t1_ready", 64'(ready), 64'd1);
    check_eq("t1_ret", {44'd0, return_x, return_y}, {44'd0, 10'd3, 10'd2});
    check_eq("t1_rgb", {48'd0, r, g, b}, {48'd0, 5'd31, 6'd0, 5'd31});
    check_eq("t1_pending", 64'(pending), 64'd0);
    tick();
    check_eq("t1_ready_once", 64'(ready), 64'd0);
    check_eq("t1_hold", {28'd0, return_x, return_y, r, g, b}, {28'd0, 10'd3, 10'd2, 5'd31, 6'd0, 5'd31});
    check_eq("t1_req_off", 64'(mem_req), 64'd0);
    fixed_en = 1'b0;

    // Ten back-to-back queries with immediate ack
    clear_results();
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; query_x = 10'(i * 7 + 1); query_y = 10'(i * 3);
      exp_q.push_back(pix(query_x, query_y, query_x, query_y, 1'b1));
      tick();
    end
    start = 1'b0;
    wait_results(10, 40);
    compare_results("t2_result");
    for (int i = 1; i < got_cyc.size(); i++)
      check_eq("t2_gap", 64'(got_cyc[i] - got_cyc[i-1]), 64'd1);
    check_eq("t2_overflow", 64'(overflow), 64'd0);
    check_eq("t2_pending", 64'(pending), 64'd0);

    // Ack stalled while twelve queries stream: eight accepted, rest dropped
    clear_results();
    ack_mode = 2'd1;
    for (int i = 0; i < 12; i++) begin
      start = 1'b1; query_x = 10'(i + 20); query_y = 10'(i + 5);
      if (i < 8) exp_q.push_back(pix(query_x, query_y, query_x, query_y, 1'b1));
      tick();
    end
    start = 1'b0;
    check_eq("t3_overflow", 64'(overflow), 64'd1);
    check_eq("t3_pending", 64'(pending), 64'd8);
    check_eq("t3_no_result", 64'(got.size()), 64'd0);
    check_eq("t3_req", 64'(mem_req), 64'd1);
    check_eq("t3_addr", 64'(mem_addr), 64'd3220);
    repeat (8) tick();
    ack_mode = 2'd0;
    wait_results(8, 30);
    compare_results("t3_result");
    check_eq("t3_pending_end", 64'(pending), 64'd0);
    check_eq("t3_overflow_sticky", 64'(overflow), 64'd1);

    // Out-of-range query (700,10)
    clear_results();
    start = 1'b1; query_x = 10'd700; query_y = 10'd10;
    tick();
    start = 1'b0;
    check_eq("t4_ready_early", 64'(ready), 64'd0);
    tick();
`ifdef COORD_CLAMP_EN
    check_eq("t4_req", 64'(mem_req), 64'd1);
    check_eq("t4_addr", 64'(mem_addr), 64'd7039);
    exp_q.push_back(pix(10'd700, 10'd10, 10'd639, 10'd10, 1'b1));
    wait_results(1, 10);
    compare_results("t4_result");
`else
    check_eq("t4_ready", 64'(ready), 64'd1);
    check_eq("t4_no_req", 64'(mem_req), 64'd0);
    check_eq("t4_ret", {28'd0, return_x, return_y, r, g, b}, {28'd0, 10'd700, 10'd10, 16'd0});
    tick();
    check_eq("t4_ready_once", 64'(ready), 64'd0);
    check_eq("t4_no_req2", 64'(mem_req), 64'd0);
`endif

    // Reset mid-fetch with three queries outstanding
    clear_results();
    ack_mode = 2'd1;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; query_x = 10'(i + 1); query_y = 10'd1;
      tick();
    end
    start = 1'b0;
    tick();
    check_eq("t5_req_before", 64'(mem_req), 64'd1);
    check_eq("t5_pending_before", 64'(pending), 64'd3);
    #5 rst_n = 1'b0;
    ack_mode = 2'd3;
    #1;
    check_eq("t5_req", 64'(mem_req), 64'd0);
    check_eq("t5_ready", 64'(ready), 64'd0);
    check_eq("t5_pending", 64'(pending), 64'd0);
    check_eq("t5_overflow", 64'(overflow), 64'd0);
    tick();
    #5 rst_n = 1'b1;
    repeat (6) tick();
    check_eq("t5_no_ready", 64'(got.size()), 64'd0);
    check_eq("t5_pending_after", 64'(pending), 64'd0);
    check_eq("t5_req_after", 64'(mem_req), 64'd0);
    ack_mode = 2'd0;

    // Two-cycle wait per read, back-to-back queries
    clear_results();
    ack_mode = 2'd2;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; query_x = 10'(100 + i * 11); query_y = 10'(200 + i);
      exp_q.push_back(pix(query_x, query_y, query_x, query_y, 1'b1));
      tick();
    end
    start = 1'b0;
    wait_results(4, 60);
    compare_results("t6_result");
    tick();
    check_eq("t6_req_end", 64'(mem_req), 64'd0);
    check_eq("t6_pending_end", 64'(pending), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
